pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the team's 4-bit ripple-carry adder.
- Operand width is split into STAGES equal chunks. Each pipeline stage resolves one chunk's ripple chain and registers the carry into the next stage.
- Fully pipelined with valid/ready handshakes at both ends, add/sub mode per transaction, unsigned carry-out and signed overflow flags.
- Sits between operand producers (register file / datapath muxes) and result consumers that may apply backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages, which equals the number of chunks; 1 <= STAGES <= WIDTH.
- CHUNK, WIDTH/STAGES, derived localparam, bits resolved per stage; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  unit accepts the transaction this cycle
- in0  input  WIDTH  operand A
- in1  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: A+B+cin; 1: A-B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out  output  WIDTH  sum/difference
- cout  output  1  unsigned carry-out (sub=1: 1 = no borrow, i.e. A>=B unsigned)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high; it is applied asynchronously and released synchronously by the system.
- Reset state:
  - All stage valid bits = 0; out_valid = 0.
  - out = 0, cout = 0, ovf = 0.
  - in_ready = 1 once rst is low.
- Arithmetic:
  - B' = sub ? ~in1 : in1.
  - c0 = sub ? 1 : cin.
  - {cout, out} = in0 + B' + c0, computed modulo 2^WIDTH with the carry kept.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and B' plus the carry registered from stage k-1 (c0 for stage 0), using a CHUNK-bit ripple chain.
  - Registers the chunk sum, carry-out, upper unprocessed operand chunks and valid bit.
  - Lower result chunks travel forward already aligned, so out is fully deskewed at the last stage.
  - The last stage also registers the MSB carry-in for ovf.
- Latency:
  - A transaction accepted on edge N presents out_valid=1 after edge N+STAGES-1, i.e. STAGES registered stages.
  - STAGES=1 gives a single registered full-width ripple, latency 1.
- Throughput: one transaction per cycle when out_ready is held high.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance, combinational from out_valid and out_ready. No combinational path from in_valid to in_ready.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - When advance=0, every stage register holds, including bubbles; no data is lost or duplicated.
  - When advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
  - out, cout and ovf are stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Output accept and input accept in the same cycle are legal; the pipeline shifts once.
  - out_ready may be high while out_valid=0, which has no effect.
- Reset mid-operation: all in-flight transactions are discarded and outputs return to reset values immediately (asynchronously).
- Operand values on cycles with in_valid=0 must not affect any output.

Decomposition:
- Shared package/header holds:
  - Default WIDTH and STAGES constants.
  - A compile-time check macro asserting WIDTH % STAGES == 0.
  - ADD/SUB encoding constants for sub.
- Natural sub-module: pipelined_adder_stage. It takes one CHUNK-bit ripple slice plus a carry register, with a hold enable; it is instantiated STAGES times in a generate loop.
- Also reuse the existing full_adder cell inside the stage.

Test Plan (WIDTH=16, STAGES=4 unless stated):
- Reset then single add: in0=0x1234, in1=0x0FFF, cin=1, sub=0 -> exactly 4 cycles later out=0x2234, cout=0, ovf=0; out_valid high for exactly one cycle with out_ready=1.
- Carry across all chunks: in0=0xFFFF, in1=0x0001, cin=0 -> out=0x0000, cout=1, ovf=0. Then in0=0x7FFF, in1=0x0001 -> out=0x8000, cout=0, ovf=1.
- Subtract: in0=0x0005, in1=0x0007, sub=1, cin=1 (ignored) -> out=0xFFFE, cout=0. Then in0=0x8000, in1=0x0001, sub=1 -> out=0x7FFF, cout=1, ovf=1.
- Back-to-back stream of 32 random ops with out_ready=1 -> 32 results in order, one per cycle after a 4-cycle fill, all matching a reference model.
- Backpressure: stream random ops, drop out_ready for 5 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, no loss or duplication, order preserved. Repeat with STAGES=1 and with STAGES=16.
- Reset mid-stream with 3 transactions in flight -> out_valid=0 and out/cout/ovf=0 immediately; no stale result appears after reset release.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// pipelined_adder_pkg: shared defaults, mode encoding and geometry check. Rev 1.0
`ifndef PIPELINED_ADDER_PKG_SV
`define PIPELINED_ADDER_PKG_SV

// Elaboration-time guard: the operand must split into equal chunks.
`define PA_CHECK_DIVISIBLE(W, S) \
  if (((W) % (S)) != 0) begin : g_width_check \
    $error("pipelined_adder: WIDTH must be a multiple of STAGES"); \
  end

package pipelined_adder_pkg;
  localparam int   DEFAULT_WIDTH  = 16;
  localparam int   DEFAULT_STAGES = 4;
  localparam logic MODE_ADD       = 1'b0;
  localparam logic MODE_SUB       = 1'b1;
endpackage

`endif
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// full_adder: single-bit full adder cell. Rev 1.0
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/pipelined_adder_stage.sv
`default_nettype none
// pipelined_adder_stage: one CHUNK-bit ripple slice with its carry/data/valid register. Rev 1.0
module pipelined_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             msb_carry
);
  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   chain;
  logic [CHUNK-1:0] chunk_sum;
  logic [WIDTH-1:0] next_sum;

  assign chain[0] = prev_carry;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (prev_a[LO+i]),
      .b  (prev_b[LO+i]),
      .ci (chain[i]),
      .s  (chunk_sum[i]),
      .co (chain[i+1])
    );
  end

  always_comb begin
    next_sum             = prev_sum;
    next_sum[LO +: CHUNK] = chunk_sum;
  end

  // Data loads only with a valid transaction, so bubble operands never reach out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      a         <= '0;
      b         <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      msb_carry <= 1'b0;
    end else if (advance) begin
      valid <= prev_valid;
      if (prev_valid) begin
        a         <= prev_a;
        b         <= prev_b;
        sum       <= next_sum;
        carry     <= chain[CHUNK];
        msb_carry <= chain[CHUNK-1];
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// pipelined_adder: STAGES-deep chunked ripple add/sub with valid/ready at both ends. Rev 1.0
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;

  `PA_CHECK_DIVISIBLE(WIDTH, STAGES)

  logic                          advance;
  logic [STAGES:0]               valid_p;
  logic [STAGES:0]               carry_p;
  logic [STAGES:1]               msb_p;
  logic [STAGES:0][WIDTH-1:0]    a_p;
  logic [STAGES:0][WIDTH-1:0]    b_p;
  logic [STAGES:0][WIDTH-1:0]    sum_p;

  // Whole pipeline moves as one unit whenever the output slot can be vacated.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign valid_p[0] = in_valid;
  assign a_p[0]     = in0;
  assign b_p[0]     = (sub == MODE_SUB) ? ~in1 : in1;
  assign sum_p[0]   = '0;
  assign carry_p[0] = (sub == MODE_ADD) ? cin : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .advance    (advance),
      .prev_valid (valid_p[k]),
      .prev_a     (a_p[k]),
      .prev_b     (b_p[k]),
      .prev_sum   (sum_p[k]),
      .prev_carry (carry_p[k]),
      .valid      (valid_p[k+1]),
      .a          (a_p[k+1]),
      .b          (b_p[k+1]),
      .sum        (sum_p[k+1]),
      .carry      (carry_p[k+1]),
      .msb_carry  (msb_p[k+1])
    );
  end

  assign out_valid = valid_p[STAGES];
  assign out       = sum_p[STAGES];
  assign cout      = carry_p[STAGES];
  assign ovf       = carry_p[STAGES] ^ msb_p[STAGES];

  // Operand copies leaving the last stage and early MSB carries have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_p[STAGES], b_p[STAGES], msb_p};
endmodule
`default_nettype wire
